// File: rtl/maxpool_1d_stream_if.sv
// Streaming handshake bundle for the 1-D max-pool block: convolution samples in, pooled maxima out.
// The slave modport faces the pooling block; master faces its environment.
interface maxpool_1d_stream_if #(
    parameter int unsigned T = 8
);
    logic                s_valid_y;
    logic                s_ready_y;
    logic signed [T-1:0] s_data_in_y;
    logic                m_valid_z;
    logic                m_ready_z;
    logic signed [T-1:0] m_data_out_z;

    modport master (
        output s_valid_y,
        output s_data_in_y,
        output m_ready_z,
        input  s_ready_y,
        input  m_valid_z,
        input  m_data_out_z
    );

    modport slave (
        input  s_valid_y,
        input  s_data_in_y,
        input  m_ready_z,
        output s_ready_y,
        output m_valid_z,
        output m_data_out_z
    );
endinterface

// File: rtl/maxpool_1d_stream.sv
// Streaming 1-D max-pool: window/stride P over vectors of L signed samples, one result per window.
// Define MAXPOOL_TAIL_EN to also emit the max of a trailing partial window when L mod P != 0.
module maxpool_1d_stream #(
    parameter int unsigned T = 8,
    parameter int unsigned L = 97,
    parameter int unsigned P = 2
) (
    input logic               clk,
    input logic               reset,
    maxpool_1d_stream_if.slave bus
);
    localparam int unsigned VW = $clog2(L);
    localparam int unsigned WW = $clog2(P);
    localparam logic [VW-1:0] VecLast = VW'(L - 1);
    localparam logic [WW-1:0] WinLast = WW'(P - 1);

    typedef enum logic [0:0] {StAccum, StHold} state_e;

    state_e              state_q, state_d;
    logic [VW-1:0]       vec_cnt_q, vec_cnt_d;
    logic [WW-1:0]       win_cnt_q, win_cnt_d;
    logic signed [T-1:0] max_q, max_d;
    logic signed [T-1:0] data_q, data_d;
    logic signed [T-1:0] cand;
    logic                accept;
    logic                win_end;
    logic                vec_end;

    // Ready is gated by reset so nothing is accepted while reset is held.
    assign bus.s_ready_y    = (state_q == StAccum) && !reset;
    assign bus.m_valid_z    = (state_q == StHold);
    assign bus.m_data_out_z = data_q;

    assign accept  = bus.s_valid_y && bus.s_ready_y;
    assign win_end = (win_cnt_q == WinLast);
    assign vec_end = (vec_cnt_q == VecLast);

    // First sample of a window loads directly; later ones fold into the running max.
    always_comb begin
        cand = bus.s_data_in_y;
        if ((win_cnt_q != '0) && (max_q > bus.s_data_in_y)) begin
            cand = max_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        vec_cnt_d = vec_cnt_q;
        win_cnt_d = win_cnt_q;
        max_d     = max_q;
        data_d    = data_q;
        case (state_q)
            StAccum: begin
                if (accept) begin
                    max_d     = cand;
                    vec_cnt_d = vec_end ? '0 : vec_cnt_q + 1'b1;
                    win_cnt_d = (win_end || vec_end) ? '0 : win_cnt_q + 1'b1;
                    if (win_end) begin
                        data_d  = cand;
                        state_d = StHold;
                    end
`ifdef MAXPOOL_TAIL_EN
                    else if (vec_end) begin
                        data_d  = cand;
                        state_d = StHold;
                    end
`endif
                end
            end
            StHold: begin
                if (bus.m_ready_z) begin
                    state_d = StAccum;
                end
            end
            default: state_d = StAccum;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StAccum;
            vec_cnt_q <= '0;
            win_cnt_q <= '0;
            max_q     <= '0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            vec_cnt_q <= vec_cnt_d;
            win_cnt_q <= win_cnt_d;
            max_q     <= max_d;
            data_q    <= data_d;
        end
    end
endmodule

// File: tb/tb_maxpool_1d_stream.sv
// Self-checking bench for maxpool_1d_stream: three parameterisations share one muxed driver,
// checked against a queue-based model of the pooling rules (honours MAXPOOL_TAIL_EN).
module tb_maxpool_1d_stream;
`ifdef MAXPOOL_TAIL_EN
    localparam bit TailEn = 1'b1;
`else
    localparam bit TailEn = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int                 sel = 0;
    logic               valid_drv = 1'b0;
    logic signed [7:0]  data_drv = '0;
    logic               mready_drv = 1'b0;
    logic               obs_ready;
    logic               obs_valid;
    logic signed [7:0]  obs_data;
    bit                 rand_mode = 1'b0;

    int n_tests = 0;
    int n_fail = 0;
    int l_cur = 4;
    int p_cur = 2;
    int acc[$];
    int exp_q[$];
    int got[$];
    int want[$];
    int not_ready_cnt = 0;

    maxpool_1d_stream_if #(.T(8)) if_a (), if_b (), if_c ();

    assign if_a.s_valid_y   = valid_drv && (sel == 0);
    assign if_a.s_data_in_y = data_drv;
    assign if_a.m_ready_z   = mready_drv && (sel == 0);
    assign if_b.s_valid_y   = valid_drv && (sel == 1);
    assign if_b.s_data_in_y = data_drv;
    assign if_b.m_ready_z   = mready_drv && (sel == 1);
    assign if_c.s_valid_y   = valid_drv && (sel == 2);
    assign if_c.s_data_in_y = data_drv;
    assign if_c.m_ready_z   = mready_drv && (sel == 2);

    maxpool_1d_stream #(.T(8), .L(4), .P(2)) u_dut_a (.clk(clk), .reset(reset), .bus(if_a));
    maxpool_1d_stream #(.T(8), .L(5), .P(2)) u_dut_b (.clk(clk), .reset(reset), .bus(if_b));
    maxpool_1d_stream #(.T(8), .L(4), .P(4)) u_dut_c (.clk(clk), .reset(reset), .bus(if_c));

    always_comb begin
        obs_ready = if_a.s_ready_y;
        obs_valid = if_a.m_valid_z;
        obs_data  = if_a.m_data_out_z;
        case (sel)
            1: begin
                obs_ready = if_b.s_ready_y;
                obs_valid = if_b.m_valid_z;
                obs_data  = if_b.m_data_out_z;
            end
            2: begin
                obs_ready = if_c.s_ready_y;
                obs_valid = if_c.m_valid_z;
                obs_data  = if_c.m_data_out_z;
            end
            default: ;
        endcase
    end

    task automatic check(input string tag, input longint got_v, input longint exp_v);
        n_tests++;
        if (got_v !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got_v, exp_v);
        end
    endtask

    task automatic check_outs(input string tag);
        check({tag, "_count"}, got.size(), want.size());
        for (int i = 0; i < want.size() && i < got.size(); i++) check(tag, got[i], want[i]);
    endtask

    // Observes handshakes at the falling edge; they complete on the following rising edge.
    task automatic monitor();
        bit                chk_vld = 0;
        bit                want_vld = 0;
        bit                prev_hold = 0;
        bit                chk_rdy = 0;
        logic signed [7:0] prev_data = '0;
        int                n, idx, k, m;
        forever begin
            @(negedge clk);
            if (reset) begin
                acc.delete();
                exp_q.delete();
                got.delete();
                not_ready_cnt = 0;
                chk_vld = 0;
                prev_hold = 0;
                chk_rdy = 0;
            end else begin
                if (!obs_ready) not_ready_cnt++;
                check("rdy_vs_vld", obs_ready, !obs_valid);
                if (chk_vld) check("vld_after_acc", obs_valid, want_vld);
                if (prev_hold) begin
                    check("hold_vld", obs_valid, 1);
                    check("hold_data", obs_data, prev_data);
                end
                if (chk_rdy) check("rdy_after_out", obs_ready, 1);
                chk_vld = 0;
                prev_hold = 0;
                chk_rdy = 0;
                if (obs_valid && mready_drv) begin
                    got.push_back(int'(obs_data));
                    check("out_pending", int'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) check("out_data", obs_data, exp_q.pop_front());
                    chk_rdy = 1;
                end else if (obs_valid) begin
                    prev_hold = 1;
                    prev_data = obs_data;
                end
                if (valid_drv && obs_ready) begin
                    acc.push_back(int'(data_drv));
                    n = acc.size();
                    idx = (n - 1) % l_cur;
                    k = 0;
                    if ((idx + 1) % p_cur == 0) k = p_cur;
                    else if (idx == l_cur - 1 && TailEn) k = l_cur % p_cur;
                    want_vld = (k > 0);
                    if (k > 0) begin
                        m = acc[n-1];
                        for (int j = 1; j < k; j++) if (acc[n-1-j] > m) m = acc[n-1-j];
                        exp_q.push_back(m);
                    end
                    chk_vld = 1;
                end
            end
        end
    endtask

    task automatic idle(input int n);
        valid_drv = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #2;
            if (rand_mode) mready_drv = ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic send(input int d);
        int budget = 0;
        bit hs;
        valid_drv = 1'b1;
        data_drv  = 8'(d);
        forever begin
            @(negedge clk);
            hs = obs_ready;
            @(posedge clk);
            #2;
            if (rand_mode) mready_drv = ($urandom_range(0, 3) != 0);
            if (hs) break;
            budget++;
            if (budget > 50) begin
                check("send_timeout", budget, 0);
                break;
            end
        end
        valid_drv = 1'b0;
    endtask

    task automatic do_reset(input int s);
        valid_drv  = 1'b0;
        mready_drv = 1'b0;
        rand_mode  = 1'b0;
        reset      = 1'b1;
        sel        = s;
        l_cur      = (s == 1) ? 5 : 4;
        p_cur      = (s == 2) ? 4 : 2;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_rdy", obs_ready, 0);
        check("rst_vld", obs_valid, 0);
        check("rst_data", obs_data, 0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        @(negedge clk);
        check("rdy_after_rst", obs_ready, 1);
        @(posedge clk);
        #2;
    endtask

    initial begin
        fork
            monitor();
        join_none

        // Basic pairs, one HOLD cycle per result.
        do_reset(0);
        mready_drv = 1'b1;
        send(3); send(-7); send(5); send(9);
        idle(3);
        want = '{3, 9};
        check_outs("basic");
        check("hold_cycles", not_ready_cnt, 2);

        // Signed comparison with negative samples.
        do_reset(0);
        mready_drv = 1'b1;
        send(-128); send(-1); send(-5); send(-6);
        idle(3);
        want = '{-1, -5};
        check_outs("negative");

        // Back-pressure: result held for 10 cycles.
        do_reset(0);
        send(3); send(-7);
        repeat (10) begin
            @(negedge clk);
            check("bp_vld", obs_valid, 1);
            check("bp_data", obs_data, 3);
            check("bp_rdy", obs_ready, 0);
        end
        @(posedge clk);
        #2;
        mready_drv = 1'b1;
        send(5); send(9);
        idle(3);
        want = '{3, 9};
        check_outs("backpressure");

        // Two back-to-back vectors wrap the vector counter.
        do_reset(0);
        mready_drv = 1'b1;
        send(1); send(2); send(3); send(4); send(9); send(0); send(0); send(5);
        idle(3);
        want = '{2, 4, 9, 5};
        check_outs("two_vectors");

        // Partial tail window (L=5, P=2), then the next vector.
        do_reset(1);
        mready_drv = 1'b1;
        send(1); send(2); send(3); send(4); send(7); send(8); send(1);
        idle(3);
        if (TailEn) want = '{2, 4, 7, 8};
        else want = '{2, 4, 8};
        check_outs("tail");

        // Reset mid-window discards the partial window (P=4).
        do_reset(2);
        mready_drv = 1'b1;
        send(100); send(50);
        #1;
        reset = 1'b1;
        #1;
        check("midwin_rst_vld", obs_valid, 0);
        check("midwin_rst_rdy", obs_ready, 0);
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        @(negedge clk);
        check("midwin_rdy_after", obs_ready, 1);
        @(posedge clk);
        #2;
        send(8); send(1); send(2); send(0);
        idle(3);
        want = '{8};
        check_outs("midwin_reset");

        // Reset while holding a result clears the output at once.
        do_reset(0);
        send(3); send(-7);
        @(negedge clk);
        check("hold_pre_rst_vld", obs_valid, 1);
        #1;
        reset = 1'b1;
        #1;
        check("hold_rst_vld", obs_valid, 0);
        check("hold_rst_data", obs_data, 0);
        check("hold_rst_rdy", obs_ready, 0);
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        mready_drv = 1'b1;
        send(5); send(9);
        idle(3);
        want = '{9};
        check_outs("hold_reset");

        // Randomised traffic with random back-pressure on every configuration.
        for (int s = 0; s < 3; s++) begin
            do_reset(s);
            rand_mode = 1'b1;
            repeat (60) begin
                if ($urandom_range(0, 3) == 0) idle(1);
                else send(int'($urandom_range(0, 255)));
            end
            rand_mode  = 1'b0;
            mready_drv = 1'b1;
            idle(6);
            check("drain_empty", exp_q.size(), 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/maxpool_1d_stream.md
MAXPOOL_1D_STREAM -- requirements
Module: maxpool_1d_stream

Interface
REQ-001 SHALL have parameter T, default 8: signed sample width in bits.
REQ-002 SHALL have parameter L, default 97: samples per input vector (N-M+1 of the upstream convolution, 128-32+1).
REQ-003 SHALL have parameter P, default 2: pool window size and stride; legal range 2..L.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-high; clears all state immediately.
REQ-006 SHALL have port s_valid_y, input, 1: upstream convolution output sample valid.
REQ-007 SHALL have port s_ready_y, output, 1: this block accepts a sample this cycle.
REQ-008 SHALL have port s_data_in_y, input, T: signed post-ReLU convolution sample.
REQ-009 SHALL have port m_valid_z, output, 1: pooled result valid.
REQ-010 SHALL have port m_ready_z, input, 1: downstream accepts the pooled result.
REQ-011 SHALL have port m_data_out_z, output, T: signed pooled maximum.

Function
REQ-012 SHALL transfer an input sample only on a cycle with s_valid_y=1 and s_ready_y=1, and an output only on a cycle with m_valid_z=1 and m_ready_z=1.
REQ-013 SHALL implement the FSM states ACCUM and HOLD: ACCUM takes input; HOLD presents a result.
REQ-014 SHALL drive s_ready_y=1 in ACCUM and s_ready_y=0 in HOLD and while reset is asserted.
REQ-015 SHALL drive m_valid_z=1 only in HOLD, with m_data_out_z stable until the output handshake.
REQ-016 SHALL track a window counter (0..P-1) and a vector counter (0..L-1), both advancing once per accepted sample.
REQ-017 SHALL load the running max with the first sample of each window and update it with max(running, sample) on later samples, using a signed comparison.
REQ-018 SHALL, when accepting the P-th sample of a window, register max(running, sample) into m_data_out_z and enter HOLD on the next edge, giving 1-cycle latency from the last accepted sample to m_valid_z=1.
REQ-019 SHALL return from HOLD to ACCUM on the output handshake; s_ready_y SHALL be 1 in the cycle after the handshake.
REQ-020 SHALL, on accepting sample index L-1, clear both counters so the next accepted sample starts window 0 of a new vector.
REQ-021 SHALL emit floor(L/P) results per vector, plus an optional tail result (see REQ-026).
REQ-022 SHALL ignore s_data_in_y whenever s_valid_y=0 or s_ready_y=0.
REQ-023 SHALL, in HOLD with m_ready_z held low indefinitely, keep m_valid_z and m_data_out_z unchanged and accept no input.

Reset
REQ-024 SHALL, on reset assertion (at any time, mid-window or mid-HOLD), immediately force: state=ACCUM, both counters=0, running max=0, m_valid_z=0, m_data_out_z=0, s_ready_y=0; a partial window SHALL be discarded.
REQ-025 SHALL drive s_ready_y=1 in the first cycle after reset deasserts.

Configuration
REQ-026 SHALL honour macro MAXPOOL_TAIL_EN when L mod P != 0. Defined: the running max of the final partial window SHALL be registered and presented in HOLD when sample L-1 is accepted. Undefined: the partial window SHALL be discarded, no output SHALL be produced for it, and the block SHALL stay in ACCUM. When L mod P = 0, the macro SHALL have no effect.

Verification
REQ-027 Bench: T=8, L=4, P=2; input 3,-7,5,9 with m_ready_z=1 -> outputs 3, then 9; s_ready_y=0 for exactly one cycle after each pair.
REQ-028 Bench: all-negative input -128,-1,-5,-6 (L=4, P=2) -> outputs -1, then -5 (signed comparison verified).
REQ-029 Bench: L=5, P=2, input 1,2,3,4,7 -> outputs 2,4,7 with MAXPOOL_TAIL_EN defined; outputs 2,4 and no third m_valid_z without it.
REQ-030 Bench: hold m_ready_z=0 for 10 cycles after first result 3 -> m_valid_z=1 and data=3 stable, s_ready_y=0 throughout; result is accepted on release.
REQ-031 Bench: assert reset after the second sample of a 4-window (P=4) -> m_valid_z=0 immediately; after release, feed 8,1,2,0 -> single output 8, with no contamination from pre-reset samples.
REQ-032 Bench: two back-to-back vectors (L=4, P=2) 1,2,3,4 then 9,0,0,5 -> outputs 2,4,9,5 (vector counter wrap verified).
